slv_stream_master: RTL

Transmit-side engine for one accelerator slave port. Accepts a frame command (mode, processing value, word count), pulls pixel words from an upstream source over a valid/ready handshake, and drives them onto the accelerator's slave-port signals (mode, data valid, proc valid, data), honouring the port's ready. One instance per slave port (slv0, slv1) in test harnesses and in the host-side front end; a 2-entry skid buffer breaks the combinational path from slave ready back to source ready.

---
 rtl/slv_stream_pkg.sv | 13 +
 rtl/stream_skid_buf.sv | 71 +++++++
 rtl/slv_stream_master.sv | 126 ++++++++++++
 3 files changed

// File: rtl/slv_stream_pkg.sv
// Shared types and default widths for the slave-port stream master.
package slv_stream_pkg;

    localparam int unsigned DEF_DW = 32;
    localparam int unsigned DEF_LW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO sitting between the source and the slave port.
// The head register drives the slave data directly, so a word accepted on
// one edge is presented on the following cycle.
module stream_skid_buf
    import slv_stream_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    occ_o
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;

    // Next-state for the two entries; simultaneous push/pop keeps order.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/slv_stream_master.sv
// Transmit engine for one accelerator slave port: takes a frame command,
// pulls cfg_len words from the source and presents them to the slave port
// through a two-entry skid buffer. src_ready depends on registered state
// only, so slv_ready never reaches it combinationally.
module slv_stream_master
    import slv_stream_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    cfg_mode,
    input  logic [7:0]    cfg_proc_val,
    input  logic [LW-1:0] cfg_len,
    input  logic [DW-1:0] src_data,
    input  logic          src_valid,
    output logic          src_ready,
    output logic [1:0]    slv_mode,
    output logic [7:0]    slv_proc_valid,
    output logic [DW-1:0] slv_data,
    output logic          slv_data_valid,
    input  logic          slv_ready,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] sent_cnt
);

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    pv_q, pv_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] acc_q, acc_d;
    logic [LW-1:0] sent_q, sent_d;

    logic [1:0]    occ;
    logic [DW-1:0] head;
    logic          push;
    logic          pop;

    assign src_ready      = (state_q == ST_RUN) && (acc_q < len_q) && (occ < 2'd2);
    assign slv_data_valid = (occ != 2'd0);
    assign slv_data       = head;
    assign push           = src_ready && src_valid;
    assign pop            = slv_data_valid && slv_ready;

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign slv_mode       = mode_q;
    assign slv_proc_valid = pv_q;
    assign sent_cnt       = sent_q;

    stream_skid_buf #(
        .DW (DW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (src_data),
        .pop_i       (pop),
        .head_o      (head),
        .occ_o       (occ)
    );

    // Frame sequencing: command latch, word counters and state transitions.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pv_d    = pv_q;
        len_d   = len_q;
        acc_d   = acc_q;
        sent_d  = sent_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = cfg_mode;
                    pv_d    = cfg_proc_val;
                    len_d   = cfg_len;
                    acc_d   = '0;
                    sent_d  = '0;
                    state_d = (cfg_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (push) begin
                    acc_d = acc_q + LW'(1);
                end
                if (pop) begin
                    sent_d = sent_q + LW'(1);
                    if (sent_d == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                mode_d  = '0;
                pv_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame state registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            pv_q    <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pv_q    <= pv_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            sent_q  <= sent_d;
        end
    end

endmodule
